fetch_unit: RTL

//  Instruction fetch stage, directly upstream of decode (decoder + immgen).

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: ISA constants, opcodes, buffer entry type.
// Imported by fetch_unit and fetch_fifo; opcodes shared with decode/immgen.
package fetch_unit_pkg;

  localparam int unsigned RV_XLEN     = 32;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; registered storage, head read combinationally.
// Ports: clk, rst, flush, push/push_data, pop -> head, empty, full, count.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    count   = cnt_q;
    head    = mem_q[rd_q];
    do_pop  = pop && !empty;
    // a full FIFO may take a push when the head leaves on the same edge
    do_push = push && (!full || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + AW'(do_pop);
      wr_d  = wr_q + AW'(do_push);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, credit-limited imem requests, {pc,instr}
// buffer to decode over valid/ready, redirect flush with stale-response drop.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RV_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [SW-1:0] credit_sum;

  logic req_fire, rsp_ok, rsp_keep, tag_pop, id_pop;

  fetch_pkt_t    buf_in, buf_head;
  logic          buf_empty, buf_full;
  logic [CW-1:0] buf_cnt;
  logic [31:0]   tag_head;
  logic          tag_empty, tag_full;
  logic [CW-1:0] tag_cnt;

  always_comb begin
    credit_sum     = SW'(out_q) + SW'(buf_cnt) + SW'(drop_q);
    imem_req_valid = !rst && (credit_sum < SW'(FIFO_DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    rsp_ok   = imem_rsp_valid && (out_q != '0);
    tag_pop  = rsp_ok && (drop_q == '0);
    rsp_keep = tag_pop && !redirect_valid;

    id_valid = !rst && !buf_empty;
    id_instr = id_valid ? buf_head.instr : '0;
    id_pc    = id_valid ? buf_head.pc : '0;
    id_pop   = id_valid && id_ready;

    buf_in.pc    = tag_head;
    buf_in.instr = imem_rsp_data;

    out_d = out_q + CW'(req_fire) - CW'(rsp_ok);

    // every request still in flight after this edge is stale on redirect
    drop_d = drop_q;
    if (redirect_valid) drop_d = out_d;
    else if (rsp_ok && drop_q != '0) drop_d = drop_q - 1'b1;

    pc_d = pc_q;
    if (redirect_valid) pc_d = word_align(redirect_pc);
    else if (req_fire) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_in),
    .pop       (id_pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_cnt)
  );

  // PCs of live (non-dropped) requests, consumed in response order
  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_cnt)
  );

  rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && out_q == '0));

  tag_balance: assert property (@(posedge clk) disable iff (rst)
    (tag_cnt + drop_q) == out_q);

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && buf_full && !id_pop) &&
    !(req_fire && tag_full && !tag_pop) &&
    !(tag_pop && tag_empty));

endmodule
